// File: rtl/ddr_req_sched_if.sv
// ddr_req_sched_if: fetch, tbus and DDR channels around the scheduler.
// slave is the scheduler's view; master is the surrounding pipeline/DDR view.
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
interface ddr_req_sched_if #(parameter int IDX_W = 19, parameter int DATA_W = 64, parameter int LINE_W = 512);
  logic pc_index_valid;
  logic [IDX_W-1:0] pc_index;
  logic pc_index_ready;
  logic [LINE_W-1:0] pc_read_inst;
  logic pc_operation_done;
  logic tbus_index_valid;
  logic [IDX_W-1:0] tbus_index;
  logic [1:0] tbus_operation_type;
  logic [DATA_W-1:0] tbus_write_data;
  logic [DATA_W-1:0] tbus_write_mask;
  logic tbus_index_ready;
  logic [DATA_W-1:0] tbus_read_data;
  logic tbus_operation_done;
  logic ddr_chip_enable;
  logic [IDX_W-1:0] ddr_index;
  logic ddr_write_enable;
  logic ddr_burst_mode;
  logic [DATA_W-1:0] ddr_opstore_write_mask;
  logic [DATA_W-1:0] ddr_opstore_write_data;
  logic [DATA_W-1:0] ddr_opload_read_data;
  logic [LINE_W-1:0] ddr_pc_read_inst;
  logic ddr_operation_done;
  logic ddr_ready;
  logic redirect_valid;
  modport slave (
    input pc_index_valid, pc_index, tbus_index_valid, tbus_index, tbus_operation_type,
          tbus_write_data, tbus_write_mask, ddr_opload_read_data, ddr_pc_read_inst,
          ddr_operation_done, ddr_ready, redirect_valid,
    output pc_index_ready, pc_read_inst, pc_operation_done, tbus_index_ready, tbus_read_data,
           tbus_operation_done, ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data
  );
  modport master (
    output pc_index_valid, pc_index, tbus_index_valid, tbus_index, tbus_operation_type,
           tbus_write_data, tbus_write_mask, ddr_opload_read_data, ddr_pc_read_inst,
           ddr_operation_done, ddr_ready, redirect_valid,
    input pc_index_ready, pc_read_inst, pc_operation_done, tbus_index_ready, tbus_read_data,
          tbus_operation_done, ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
          ddr_opstore_write_mask, ddr_opstore_write_data
  );
endinterface

// File: rtl/ddr_req_sched.sv
// ddr_req_sched: single-outstanding DDR scheduler, tbus priority with pc aging, redirect squash.
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
module ddr_req_sched #(
  parameter int IDX_W = 19,
  parameter int DATA_W = 64,
  parameter int LINE_W = 512,
  parameter int AGE_MAX = 4
) (
  input logic clock,
  input logic reset_n,
  ddr_req_sched_if.slave bus
);
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {NONE, PC, TBUS_RD, TBUS_WR} owner_t;
  state_t state, state_nx;
  owner_t owner;
  logic flush;
  logic [AGE_W-1:0] age;
  logic arb, pc_win, tbus_win, fire, done, tbus_wr, pc_ok;
  logic [IDX_W-1:0] idx_sel;
  always_comb begin
    arb = reset_n && state == IDLE && bus.ddr_ready;
    pc_win = arb && bus.pc_index_valid && !bus.redirect_valid &&
             (!bus.tbus_index_valid || age >= AGE_W'(AGE_MAX));
    tbus_win = arb && bus.tbus_index_valid && !pc_win;
    fire = pc_win || tbus_win;
    tbus_wr = bus.tbus_operation_type == `TBUS_WRITE;
    idx_sel = pc_win ? bus.pc_index : bus.tbus_index;
    // early completion in ISSUE is accepted just like in WAIT
    done = reset_n && state != IDLE && bus.ddr_operation_done;
    pc_ok = done && owner == PC && !flush && !bus.redirect_valid;
    state_nx = state == IDLE ? (fire ? ISSUE : IDLE) : (done ? IDLE : WAIT);
    bus.pc_index_ready = pc_win;
    bus.tbus_index_ready = tbus_win;
    bus.pc_operation_done = pc_ok;
    bus.pc_read_inst = pc_ok ? bus.ddr_pc_read_inst : LINE_W'(0);
    bus.tbus_operation_done = done && (owner == TBUS_RD || owner == TBUS_WR);
    bus.tbus_read_data = done && owner == TBUS_RD ? bus.ddr_opload_read_data : DATA_W'(0);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner <= NONE;
      flush <= 1'b0;
      age <= '0;
    end else begin
      if (!bus.pc_index_valid || pc_win) age <= '0;
      else if (arb && age < AGE_W'(AGE_MAX)) age <= age + 1'b1;
      if (done) begin
        owner <= NONE;
        flush <= 1'b0;
      end else if (fire) begin
        owner <= pc_win ? PC : (tbus_wr ? TBUS_WR : TBUS_RD);
        flush <= 1'b0;
      end else if (owner == PC && bus.redirect_valid) flush <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.ddr_chip_enable <= 1'b0;
      bus.ddr_index <= '0;
      bus.ddr_write_enable <= 1'b0;
      bus.ddr_burst_mode <= 1'b0;
      bus.ddr_opstore_write_mask <= '0;
      bus.ddr_opstore_write_data <= '0;
    end else begin
      bus.ddr_chip_enable <= fire;
      if (fire) begin
        bus.ddr_index <= idx_sel;
        bus.ddr_write_enable <= tbus_win && tbus_wr;
        bus.ddr_burst_mode <= pc_win;
      end
      if (tbus_win && tbus_wr) begin
        bus.ddr_opstore_write_mask <= bus.tbus_write_mask;
        bus.ddr_opstore_write_data <= bus.tbus_write_data;
      end
    end
  end
endmodule
